// File: rtl/acc_sched.sv
`default_nettype none
// ============================================================================
// Module   : acc_sched
// Purpose  : Two-requester round-robin scheduler for an external accumulator.
//            Each granted operation walks IDLE -> SETUP -> PULSE -> SAMPLE ->
//            DONE. The winner's operand is presented on acc_d, and one
//            registered strobe is issued on acc_clk. The accumulator output
//            is captured into result, and the winner receives a one-cycle ack.
// Ports    : clk            system clock (rising edge)
//            rst            asynchronous active-low reset
//            req0/d0/ack0   requester 0 level request, operand, done pulse
//            req1/d1/ack1   requester 1 level request, operand, done pulse
//            acc_d          operand to accumulator d input
//            acc_clk        accumulate strobe to accumulator clock input
//            acc_q          accumulator output
//            result         acc_q captured for the completed operation
//            grant          index of the requester owning the operation
//            busy           high in every state except IDLE
//            cnt0/cnt1      8-bit saturating per-requester completion counts
//                           (present only when ACC_SCHED_STATS_EN is defined)
// Options  : ACC_SCHED_STATS_EN - adds the cnt0/cnt1 ports and counters.
// Revision : 1.0 - initial release
// ============================================================================
module acc_sched #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] d0,
    output logic         ack0,
    input  logic         req1,
    input  logic [W-1:0] d1,
    output logic         ack1,
    output logic [W-1:0] acc_d,
    output logic         acc_clk,
    input  logic [W-1:0] acc_q,
    output logic [W-1:0] result,
    output logic         grant,
`ifdef ACC_SCHED_STATS_EN
    output logic [7:0]   cnt0,
    output logic [7:0]   cnt1,
`endif
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_PULSE  = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state_q;
    logic   last_q;     // requester served most recently
    logic   win_d;      // arbitration winner for a grant taken this cycle

    // A lone request wins outright; on a tie, the requester not served last wins.
    assign win_d = (req0 && req1) ? ~last_q : req1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;    // lets requester 0 win the first tie
            grant   <= 1'b0;
            acc_d   <= '0;
            acc_clk <= 1'b0;
            result  <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        grant   <= win_d;
                        last_q  <= win_d;
                        acc_d   <= win_d ? d1 : d0;
                        busy    <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // Registered strobe: high for exactly the PULSE cycle.
                    acc_clk <= 1'b1;
                    state_q <= S_PULSE;
                end
                S_PULSE: begin
                    acc_clk <= 1'b0;
                    state_q <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    result  <= acc_q;
                    ack0    <= ~grant;
                    ack1    <= grant;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    acc_clk <= 1'b0;
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ACC_SCHED_STATS_EN
    // Completion counters step once per DONE cycle and stick at 255.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0 <= 8'd0;
            cnt1 <= 8'd0;
        end else if (state_q == S_DONE) begin
            if (!grant && cnt0 != 8'hFF) begin
                cnt0 <= cnt0 + 8'd1;
            end
            if (grant && cnt1 != 8'hFF) begin
                cnt1 <= cnt1 + 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_acc_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_sched
// Purpose  : Self-checking bench for acc_sched. It places an accumulator model
//            on acc_d/acc_clk/acc_q. Each operation is checked against an
//            arithmetic reference made of a running sum modulo 2^W and a
//            round-robin last-served flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_sched;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0;
    logic [W-1:0] d0 = '0;
    logic         ack0;
    logic         req1 = 1'b0;
    logic [W-1:0] d1 = '0;
    logic         ack1;
    logic [W-1:0] acc_d;
    logic         acc_clk;
    logic [W-1:0] acc_q;
    logic [W-1:0] result;
    logic         grant;
    logic         busy;
`ifdef ACC_SCHED_STATS_EN
    logic [7:0]   cnt0;
    logic [7:0]   cnt1;
`endif

    acc_sched #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .d0      (d0),
        .ack0    (ack0),
        .req1    (req1),
        .d1      (d1),
        .ack1    (ack1),
        .acc_d   (acc_d),
        .acc_clk (acc_clk),
        .acc_q   (acc_q),
        .result  (result),
        .grant   (grant),
`ifdef ACC_SCHED_STATS_EN
        .cnt0    (cnt0),
        .cnt1    (cnt1),
`endif
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // External accumulator, sharing the scheduler reset.
    logic [W-1:0] acc_reg;
    always_ff @(posedge acc_clk or negedge rst) begin
        if (!rst) acc_reg <= '0;
        else      acc_reg <= acc_reg + acc_d;
    end
    assign acc_q = acc_reg;

    int pulses = 0;
    always @(posedge acc_clk) pulses++;

    int passed = 0;
    int total  = 0;

    // Reference state
    logic [W-1:0] exp_sum;
    logic         last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        exp_sum = '0;
        last    = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    // One operation from IDLE, using the current req/d inputs.
    task automatic do_op(input string tag);
        int           n;
        logic         win;
        logic [W-1:0] opnd;
        if (req0 && req1) win = ~last;
        else              win = req1;
        opnd    = win ? d1 : d0;
        exp_sum = exp_sum + opnd;
        last    = win;
        pulses  = 0;
        n = 0;
        do begin
            step();
            n++;
        end while (!(ack0 || ack1) && n < 12);
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_ack0"}, ack0, !win);
        chk({tag, "_ack1"}, ack1, win);
        chk({tag, "_grant"}, grant, win);
        chk({tag, "_result"}, result, exp_sum);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_acc_d"}, acc_d, opnd);
        chk({tag, "_busy_done"}, busy, 1);
        // Served requester drops at the edge ending its ack cycle.
        if (win) req1 = 1'b0;
        else     req0 = 1'b0;
        step();
        chk({tag, "_ack_clear"}, {ack0, ack1}, 0);
        chk({tag, "_busy_idle"}, busy, 0);
        chk({tag, "_result_hold"}, result, exp_sum);
    endtask

    initial begin
        exp_sum = '0;
        last    = 1'b1;
        #1;
        // Outputs forced during reset
        chk("rst_acc_clk", acc_clk, 0);
        chk("rst_ack", {ack0, ack1}, 0);
        chk("rst_acc_d", acc_d, 0);
        chk("rst_result", result, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        do_reset();

        // Single requester 0, then single requester 1
        req0 = 1'b1; d0 = 4'd3;
        do_op("r0_single");
        req1 = 1'b1; d1 = 4'd5;
        do_op("r1_single");

        // Simultaneous requests after reset: requester 0 first, then alternation
        do_reset();
        req0 = 1'b1; d0 = 4'd1;
        req1 = 1'b1; d1 = 4'd2;
        do_op("tie_first");
        req0 = 1'b1; d0 = 4'd4;     // new operand while requester 1 still waits
        do_op("tie_second");
        req1 = 1'b1; d1 = 4'd7;
        do_op("tie_third");

        // Wrap-around: 14 + 5 = 3 (mod 16)
        do_reset();
        req0 = 1'b1; d0 = 4'd14;
        do_op("wrap_load");
        req0 = 1'b1; d0 = 4'd5;
        do_op("wrap");

        // Reset during PULSE discards the operation
        do_reset();
        req0 = 1'b1; d0 = 4'd9;
        step();
        step();
        chk("midrst_in_pulse", acc_clk, 1);
        rst = 1'b0;
        #1;
        chk("midrst_acc_clk", acc_clk, 0);
        chk("midrst_ack", {ack0, ack1}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        req0 = 1'b0;
        exp_sum = '0;
        last    = 1'b1;
        step();
        rst = 1'b1;
        step();
        req0 = 1'b1; d0 = 4'd6;
        do_op("after_rst");

        // Randomized mix of single and contending requests
        for (int i = 0; i < 40; i++) begin
            if (!req0 && $urandom_range(0, 1) == 1) begin
                req0 = 1'b1;
                d0   = W'($urandom);
            end
            if (!req1 && $urandom_range(0, 1) == 1) begin
                req1 = 1'b1;
                d1   = W'($urandom);
            end
            if (!req0 && !req1) begin
                req0 = 1'b1;
                d0   = W'($urandom);
            end
            do_op("rand");
        end

`ifdef ACC_SCHED_STATS_EN
        do_reset();
        for (int i = 0; i < 300; i++) begin
            req0 = 1'b1;
            d0   = W'($urandom);
            do_op("stats");
        end
        chk("cnt0_sat", cnt0, 8'd255);
        chk("cnt1_zero", cnt1, 8'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
